reg_file: RTL and testbench
===========================

# reg_file

Architectural register file for the single-cycle CPU: 32 general-purpose registers, two combinational read ports and one clocked write port. Read port 1 drives the register operand of the ALU operand-1 source select. Read port 2 drives the operand-2 and store-data paths. The block also holds a per-register pending scoreboard for multi-cycle producers such as loads, and raises STALL when an instruction reads a register whose result has not yet been written back.

## Interface
- DATA_W, 32, register width in bits
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only

- CLK  in  1  system clock; all state updates on the rising edge
- RSTN  in  1  reset, asynchronous, active-low
- RA1  in  5  read address, port 1 (rs1)
- RA2  in  5  read address, port 2 (rs2)
- RA1_USE  in  1  current instruction consumes port 1
- RA2_USE  in  1  current instruction consumes port 2
- RD1  out  DATA_W  read data, port 1
- RD2  out  DATA_W  read data, port 2
- WE  in  1  write enable
- WA  in  5  write address
- WD  in  DATA_W  write data
- PEND_SET  in  1  a multi-cycle result for PEND_RA has been issued
- PEND_RA  in  5  destination register of that result
- PEND  out  32  pending vector; bit n = register n awaiting write-back
- STALL  out  1  operand hazard; the core must hold PC and instruction

## Operation
- Storage: regs[1..31], each DATA_W bits. Register 0 is not stored and always reads 0.
- Write: on the rising CLK, when WE=1 and WA≠0, regs[WA] ← WD. A write with WA=0 is ignored.
- Read port n (combinational):
  - RAn=0 → RDn=0.
  - Otherwise, when BYPASS=1, WE=1 and WA=RAn → RDn=WD.
  - Otherwise RDn=regs[RAn].
- Pending vector, updated on each rising CLK:
  - Clear: WE=1 and WA≠0 → PEND[WA] ← 0.
  - Set: PEND_SET=1 and PEND_RA≠0 → PEND[PEND_RA] ← 1.
  - Set and clear to the same register in the same cycle → set wins; a new producer has been issued.
  - PEND_SET to an already-pending register → the bit stays 1. There is no count; only one producer per register is in flight.
  - PEND[0] is constant 0.
- Hazard (combinational):
  - hazn = RAn_USE & PEND[RAn] & ~(BYPASS & WE & WA=RAn).
  - STALL = haz1 | haz2.
  - With BYPASS=0, a pending register stalls until the cycle after its write-back.
- Reset: RSTN=0 immediately clears regs[1..31] and PEND to 0, regardless of CLK. This also applies mid-operation; writes or sets in flight are discarded. When RSTN is released, the first rising edge performs normal updates.

## Timing
- Read latency: 0 cycles (combinational from RAn, WE, WA, WD).
- Write latency: with BYPASS=1, visible on the read ports in the same cycle; with BYPASS=0, visible from the cycle after the edge.
- PEND updates appear 1 cycle after the PEND_SET/WE edge. STALL follows PEND combinationally.
- Reset values: RD1=RD2=0 (all registers 0), PEND=0, STALL=0.
- No handshake on the write port: every WE=1 cycle commits exactly one write. The producer must not assert WE and still expect the stall to hold.

## Test plan
- Reset: drive RSTN=0 mid-cycle with regs loaded → RD1=RD2=0 and PEND=0 before the next edge; STALL=0.
- Write/read: WE=1, WA=5, WD=0xDEADBEEF, then RA1=5, RA2=0 next cycle → RD1=0xDEADBEEF, RD2=0. A write with WA=0, WD=0x1234 → RA1=0 still reads 0.
- Bypass: regs[7]=0x11, then in the same cycle WE=1, WA=7, WD=0x22 with RA1=RA2=7 → RD1=RD2=0x22 when BYPASS=1, and 0x11 when BYPASS=0.
- Load hazard: PEND_SET=1, PEND_RA=9 → next cycle PEND[9]=1; RA2=9 with RA2_USE=1 → STALL=1; RA2_USE=0 → STALL=0. Then WE=1, WA=9, WD=0x55 → that cycle STALL=0 with BYPASS=1, and RD2=0x55; the following cycle PEND[9]=0.
- Simultaneous set/clear: PEND[3]=1, then WE=1, WA=3 together with PEND_SET=1, PEND_RA=3 → regs[3] updated and PEND[3] stays 1.
- Register 0 scoreboard: PEND_SET=1, PEND_RA=0 → PEND stays 0; RA1=0 with RA1_USE=1 → STALL=0.

Source files
------------

// File: rtl/reg_file_if.sv
// reg_file port bundle: read ports, write port,
// pending scoreboard and stall.
interface reg_file_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        RA1;
  logic [4:0]        RA2;
  logic              RA1_USE;
  logic              RA2_USE;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              WE;
  logic [4:0]        WA;
  logic [DATA_W-1:0] WD;
  logic              PEND_SET;
  logic [4:0]        PEND_RA;
  logic [31:0]       PEND;
  logic              STALL;

  modport master (
    output RA1, RA2, RA1_USE, RA2_USE,
    output WE, WA, WD, PEND_SET, PEND_RA,
    input  RD1, RD2, PEND, STALL
  );

  modport slave (
    input  RA1, RA2, RA1_USE, RA2_USE,
    input  WE, WA, WD, PEND_SET, PEND_RA,
    output RD1, RD2, PEND, STALL
  );
endinterface

// File: rtl/reg_file.sv
// 32-entry register file, 2R/1W, with a pending
// scoreboard for multi-cycle producers and a stall flag.
module reg_file #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic      CLK,
  input logic      RSTN,
  reg_file_if.slave bus
);

  logic [DATA_W-1:0] r_regs [1:31];
  logic [31:1]       r_pend;

  logic w_wr;
  logic w_set;
  logic w_hit1;
  logic w_hit2;
  logic w_haz1;
  logic w_haz2;
  logic [31:0] w_pend;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_wr  = bus.WE && (bus.WA != 5'd0);
  assign w_set = bus.PEND_SET && (bus.PEND_RA != 5'd0);

  assign w_hit1 = BYPASS && bus.WE
                  && (bus.WA == bus.RA1);
  assign w_hit2 = BYPASS && bus.WE
                  && (bus.WA == bus.RA2);

  assign w_pend = {r_pend, 1'b0};

  // register storage; r0 is never stored
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 1; i < 32; i++)
        r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[bus.WA] <= bus.WD;
    end
  end

  // scoreboard: write-back clears, issue sets; set wins
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pend <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_set && (bus.PEND_RA == 5'(i)))
          r_pend[i] <= 1'b1;
        else if (w_wr && (bus.WA == 5'(i)))
          r_pend[i] <= 1'b0;
      end
    end
  end

  // read port 1: r0, then forwarded write, then storage
  always_comb begin
    w_rd1 = '0;
    if (bus.RA1 == 5'd0)
      w_rd1 = '0;
    else if (w_hit1)
      w_rd1 = bus.WD;
    else
      w_rd1 = r_regs[bus.RA1];
  end

  // read port 2: r0, then forwarded write, then storage
  always_comb begin
    w_rd2 = '0;
    if (bus.RA2 == 5'd0)
      w_rd2 = '0;
    else if (w_hit2)
      w_rd2 = bus.WD;
    else
      w_rd2 = r_regs[bus.RA2];
  end

  // a pending operand stalls unless forwarded this cycle
  always_comb begin
    w_haz1 = bus.RA1_USE && w_pend[bus.RA1] && !w_hit1;
    w_haz2 = bus.RA2_USE && w_pend[bus.RA2] && !w_hit2;
  end

  assign bus.RD1   = w_rd1;
  assign bus.RD2   = w_rd2;
  assign bus.PEND  = w_pend;
  assign bus.STALL = w_haz1 || w_haz2;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one instance with
// forwarding, one without, driven in lockstep.
module tb_reg_file;

  logic        CLK;
  logic        RSTN;
  logic [4:0]  ra1, ra2, wa, pra;
  logic        u1, u2, we, pset;
  logic [31:0] wd;

  int n_tests;
  int n_fail;

  reg_file_if #(.DATA_W(32)) bb();
  reg_file_if #(.DATA_W(32)) bn();

  assign bb.RA1 = ra1;      assign bn.RA1 = ra1;
  assign bb.RA2 = ra2;      assign bn.RA2 = ra2;
  assign bb.RA1_USE = u1;   assign bn.RA1_USE = u1;
  assign bb.RA2_USE = u2;   assign bn.RA2_USE = u2;
  assign bb.WE = we;        assign bn.WE = we;
  assign bb.WA = wa;        assign bn.WA = wa;
  assign bb.WD = wd;        assign bn.WD = wd;
  assign bb.PEND_SET = pset; assign bn.PEND_SET = pset;
  assign bb.PEND_RA = pra;  assign bn.PEND_RA = pra;

  reg_file #(.DATA_W(32), .BYPASS(1'b1)) u_byp (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bb)
  );

  reg_file #(.DATA_W(32), .BYPASS(1'b0)) u_nob (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ra1 = 0; ra2 = 0; u1 = 0; u2 = 0;
    we = 0; wa = 0; wd = 0; pset = 0; pra = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    RSTN = 1'b0;
    ra1 = 5'd5;
    ra2 = 5'd9;
    #3;
    chk("rst_rd1", bb.RD1, 32'h0);
    chk("rst_rd2", bb.RD2, 32'h0);
    chk("rst_pend", bb.PEND, 32'h0);
    chk("rst_stall", {31'b0, bb.STALL}, 32'h0);
    #9 RSTN = 1'b1;
    tick();

    // write then read
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    idle();
    ra1 = 5; ra2 = 0;
    #1;
    chk("wr_rd1_b", bb.RD1, 32'hDEADBEEF);
    chk("wr_rd1_n", bn.RD1, 32'hDEADBEEF);
    chk("wr_rd2_0", bb.RD2, 32'h0);

    // write to r0 ignored
    we = 1; wa = 0; wd = 32'h1234;
    tick();
    idle();
    #1;
    chk("r0_rd_b", bb.RD1, 32'h0);
    chk("r0_rd_n", bn.RD1, 32'h0);

    // forwarding
    we = 1; wa = 7; wd = 32'h11;
    tick();
    wd = 32'h22; ra1 = 7; ra2 = 7;
    #1;
    chk("byp_rd1_b", bb.RD1, 32'h22);
    chk("byp_rd2_b", bb.RD2, 32'h22);
    chk("byp_rd1_n", bn.RD1, 32'h11);
    chk("byp_rd2_n", bn.RD2, 32'h11);
    tick();
    we = 0;
    #1;
    chk("byp_after_n", bn.RD1, 32'h22);

    // load hazard
    idle();
    pset = 1; pra = 9;
    tick();
    pset = 0;
    chk("ld_pend", bb.PEND, 32'h200);
    ra2 = 9; u2 = 1;
    #1;
    chk("ld_stall_b", {31'b0, bb.STALL}, 32'h1);
    chk("ld_stall_n", {31'b0, bn.STALL}, 32'h1);
    u2 = 0;
    #1;
    chk("ld_nouse", {31'b0, bb.STALL}, 32'h0);
    u2 = 1; we = 1; wa = 9; wd = 32'h55;
    #1;
    chk("ld_wb_stall_b", {31'b0, bb.STALL}, 32'h0);
    chk("ld_wb_rd2_b", bb.RD2, 32'h55);
    chk("ld_wb_stall_n", {31'b0, bn.STALL}, 32'h1);
    tick();
    we = 0;
    #1;
    chk("ld_clr_b", bb.PEND, 32'h0);
    chk("ld_clr_n", bn.PEND, 32'h0);
    chk("ld_go_n", {31'b0, bn.STALL}, 32'h0);
    chk("ld_rd2_n", bn.RD2, 32'h55);

    // set and clear same register: set wins
    idle();
    pset = 1; pra = 3;
    tick();
    chk("sc_pend0", bb.PEND, 32'h8);
    we = 1; wa = 3; wd = 32'h33;
    tick();
    idle();
    ra1 = 3;
    #1;
    chk("sc_rd1", bn.RD1, 32'h33);
    chk("sc_pend", bn.PEND, 32'h8);
    pset = 1; pra = 3;
    tick();
    pset = 0;
    chk("sc_reset_again", bb.PEND, 32'h8);
    we = 1; wa = 3; wd = 32'h34;
    tick();
    idle();
    chk("sc_clear", bb.PEND, 32'h0);

    // r0 never pends
    pset = 1; pra = 0;
    tick();
    pset = 0;
    chk("r0_pend", bb.PEND, 32'h0);
    ra1 = 0; u1 = 1;
    #1;
    chk("r0_stall", {31'b0, bb.STALL}, 32'h0);

    // mid-operation reset
    idle();
    we = 1; wa = 12; wd = 32'hA5;
    pset = 1; pra = 13;
    tick();
    idle();
    ra1 = 12; ra2 = 13; u2 = 1;
    #1;
    chk("mr_pre_rd1", bb.RD1, 32'hA5);
    chk("mr_pre_stall", {31'b0, bb.STALL}, 32'h1);
    we = 1; wa = 12; wd = 32'hFF;
    pset = 1; pra = 14;
    #1 RSTN = 1'b0;
    we = 0; pset = 0;
    #1;
    chk("mr_rd1_b", bb.RD1, 32'h0);
    chk("mr_rd1_n", bn.RD1, 32'h0);
    chk("mr_pend", bb.PEND, 32'h0);
    chk("mr_stall", {31'b0, bb.STALL}, 32'h0);
    ra1 = 5;
    #1;
    chk("mr_rd_r5", bn.RD1, 32'h0);
    tick();
    #2 RSTN = 1'b1;
    we = 1; wa = 12; wd = 32'h77;
    tick();
    we = 0;
    ra1 = 12;
    #1;
    chk("post_rst_wr", bn.RD1, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
